// File: rtl/tdc_readout_arbiter.sv
// Round-robin arbiter that funnels armed TDC channel captures into a shared
// first-word-fall-through timestamp FIFO drained by the CPU.
module tdc_readout_arbiter #(
  parameter int NCHAN = 4,
  parameter int CH_W  = 2,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NCHAN-1:0]            en_i,
  input  logic [NCHAN-1:0]            ch_valid_i,
  input  logic [NCHAN*TS_W-1:0]       ch_ts_i,
  output logic [NCHAN-1:0]            ch_ack_o,
  input  logic                        rd_en_i,
  output logic                        rd_valid_o,
  output logic [CH_W-1:0]             rd_ch_o,
  output logic [TS_W-1:0]             rd_ts_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        ovf_o,
  input  logic                        clr_ovf_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACK} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [NCHAN-1:0]  ack_q, ack_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CH_W-1:0]   hch_q, hch_d;
  logic [TS_W-1:0]   hts_q, hts_d;

  logic [CH_W-1:0]   mem_ch [DEPTH];
  logic [TS_W-1:0]   mem_ts [DEPTH];

  logic [NCHAN-1:0]  req, req_rot;
  logic              found, full, empty, push, pop, ovf_set;
  logic [CH_W-1:0]   off, gnt;
  logic [CH_W:0]     gsum;
  logic [TS_W-1:0]   gnt_ts;

  assign req   = ch_valid_i & en_i;
  assign found = |req;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = rd_en_i && !empty;

  // Rotate requests so the search starts at rr_q, take the lowest set bit,
  // then map the offset back to an absolute channel index.
  always_comb begin
    req_rot = NCHAN'({req, req} >> rr_q);
    off     = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (req_rot[i]) off = CH_W'(i);
    end
    gsum = {1'b0, rr_q} + {1'b0, off};
    if (gsum >= (CH_W+1)'(NCHAN)) gsum = gsum - (CH_W+1)'(NCHAN);
    gnt = gsum[CH_W-1:0];
  end

  always_comb begin
    gnt_ts = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (gnt == CH_W'(k)) gnt_ts = ch_ts_i[k*TS_W +: TS_W];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = '0;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !full) begin
          push    = 1'b1;
          ack_d   = NCHAN'(1) << gnt;
          rr_d    = (gnt == CH_W'(NCHAN - 1)) ? '0 : gnt + CH_W'(1);
          state_d = ACK;
        end else if (found) begin
          ovf_set = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)        ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  // Head register mirrors the oldest entry and keeps its value once drained.
  always_comb begin
    rd_nxt = rd_q + PTR_W'(1);
    wr_d   = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d   = pop ? rd_nxt : rd_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    hch_d = hch_q;
    hts_d = hts_q;
    if (push && (empty || (pop && cnt_q == CNT_W'(1)))) begin
      hch_d = gnt;
      hts_d = gnt_ts;
    end else if (pop && cnt_q > CNT_W'(1)) begin
      hch_d = mem_ch[rd_nxt];
      hts_d = mem_ts[rd_nxt];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ack_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hch_q   <= '0;
      hts_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hch_q   <= hch_d;
      hts_q   <= hts_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ch[wr_q] <= gnt;
      mem_ts[wr_q] <= gnt_ts;
    end
  end

  assign ch_ack_o   = ack_q;
  assign rd_valid_o = !empty;
  assign rd_ch_o    = hch_q;
  assign rd_ts_o    = hts_q;
  assign count_o    = cnt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: doc/tdc_readout_arbiter.md
Name: tdc_readout_arbiter

Overview:
Shares one timestamp readout FIFO between NCHAN TDC capture channels in the user project area. Each armed TDC channel raises a valid flag together with its timestamp. The arbiter grants channels round-robin, pushes {channel, timestamp} into an internal first-word-fall-through FIFO, and pulses a per-channel ack that rearms the channel. The CPU drains the FIFO through the Wishbone register bank.

Parameters:
NCHAN, 4, number of TDC channels arbitrated (2..8)
CH_W, 2, channel-ID width; must satisfy 2**CH_W >= NCHAN
TS_W, 32, timestamp width (coarse count concatenated with fine code)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  NCHAN  per-channel enable; a disabled channel is never granted or acked
ch_valid_i  in  NCHAN  channel holds a capture; held high until acked
ch_ts_i  in  NCHAN*TS_W  timestamps; channel k occupies bits [k*TS_W +: TS_W]
ch_ack_o  out  NCHAN  one-cycle rearm pulse to the granted channel
rd_en_i  in  1  pop the head entry; ignored when rd_valid_o=0
rd_valid_o  out  1  FIFO not empty
rd_ch_o  out  CH_W  head entry channel ID
rd_ts_o  out  TS_W  head entry timestamp
count_o  out  log2(DEPTH)+1  FIFO occupancy
ovf_o  out  1  sticky overflow flag
clr_ovf_i  in  1  clears ovf_o

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, rr_ptr=0, FIFO empty, ch_ack_o=0, rd_valid_o=0, rd_ch_o=0, rd_ts_o=0, count_o=0, ovf_o=0.
- req = ch_valid_i & en_i.
- FSM state IDLE:
  - If req!=0 and count_o<DEPTH: grant g = first set req bit searching circularly from rr_ptr upward.
  - On the same edge: write {g, ts[g]} into the FIFO, set ch_ack_o[g]=1 (registered, visible the next cycle), set rr_ptr=(g+1) mod NCHAN, go to ACK.
  - Otherwise stay in IDLE.
- FSM state ACK:
  - Hold ch_ack_o[g]=1 for exactly this one cycle, then drop it. Go to IDLE.
  - req is not sampled in ACK. The channel deasserts valid on the edge where it sees ack, so no double grant occurs.
  - Maximum throughput is one grant every 2 cycles.
- Full: the grant decision uses the registered count_o. At count_o=DEPTH no grant is made, even if a pop happens in the same cycle. Requesters keep waiting with valid held.
- Overflow: ovf_o is set on an IDLE cycle with req!=0 and count_o=DEPTH. clr_ovf_i clears it. If set and clear coincide, set wins.
- FIFO is first-word-fall-through:
  - rd_ch_o and rd_ts_o show the head entry whenever rd_valid_o=1.
  - rd_en_i with rd_valid_o=1 advances the head on the edge. Data is valid the cycle after the push.
  - Simultaneous push and pop leaves count_o unchanged.
  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH. Occupancy is tracked by count_o, not by pointer compare.
  - When empty, rd_ch_o and rd_ts_o hold their last value.
- Enable changes:
  - Deasserting en_i[k] while channel k is in ACK does not cancel the pending ack pulse.
  - Deasserting en_i[k] in IDLE removes k from arbitration the same cycle.
- The timestamp is captured from ch_ts_i at the grant edge. Later changes of ch_ts_i are not recorded.
- Reset mid-operation clears all state immediately, including any in-flight ack and all FIFO contents. No partial entry is retained.

Test Plan:
- Single channel: en_i=4'b0001, ch0 valid with ts=32'h0000_1234 → ch_ack_o=4'b0001 for 1 cycle, 2 cycles after valid. Then rd_valid_o=1, rd_ch_o=0, rd_ts_o=32'h1234, count_o=1. Pulse rd_en_i → count_o=0, rd_valid_o=0.
- Round-robin: all 4 enabled, all valid at once with ts=k+100 → grants in order 0,1,2,3, one every 2 cycles. FIFO pops return ch 0..3 with ts 100..103. Re-assert ch3 and ch0 together with rr_ptr=0 → ch0 is granted first.
- Full and overflow: DEPTH=8, 8 captures, no reads → count_o=8 and ch1 stays valid without ack, ovf_o=1. One pop → ch1 is granted 1 cycle later and count_o returns to 8. clr_ovf_i then clears ovf_o. Set and clear in the same cycle → ovf_o stays 1.
- Disabled channel: en_i=4'b1011, ch2 valid → no ack for ch2 and count_o unchanged over 50 cycles. Setting en_i[2]=1 → ch2 is granted.
- Concurrent push and pop at count_o=7 → count_o stays 7 and FIFO order is preserved. Full wrap-around over 20 entries → FIFO order preserved.
- Reset mid-operation: assert rst_n_i=0 during ACK with count_o=5 → ch_ack_o=0, count_o=0, rd_valid_o=0, ovf_o=0 asynchronously. After release, first grant is ch0.
